// File: rtl/ps2_pkg.sv
// Shared definitions for PS/2 key events: entry layout and the packed event type
// consumed by the key FIFO and downstream keymap logic.
package ps2_pkg;

  localparam int ENTRY_W  = 10;
  localparam int SCAN_LSB = 0;
  localparam int REL_BIT  = 8;
  localparam int EXT_BIT  = 9;

  typedef struct packed {
    logic       extended;
    logic       released;
    logic [7:0] scancode;
  } key_event_t;

  function automatic key_event_t make_event(input logic ext, input logic rel,
                                            input logic [7:0] code);
    key_event_t ev;
    ev.extended = ext;
    ev.released = rel;
    ev.scancode = code;
    return ev;
  endfunction

endpackage

// File: rtl/ps2_fifo_mem.sv
// Simple dual-port storage for the key FIFO: synchronous write, asynchronous read,
// no reset (contents are only ever observed through valid pointer ranges).
module ps2_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ps2_key_fifo.sv
// First-word-fall-through FIFO of PS/2 key events with a typematic repeat filter
// and a sticky overflow flag.
module ps2_key_fifo
  import ps2_pkg::*;
#(
  parameter int   DEPTH          = 8,
  parameter logic FILTER_DEFAULT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   kb_interrupt,
  input  logic [7:0]             scancode,
  input  logic                   released,
  input  logic                   extended,
  input  logic                   rd,
  input  logic                   clear,
  input  logic                   filter_en,
  input  logic                   cfg_we,
  output logic [ENTRY_W-1:0]     dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          last_valid_q, last_valid_d;
  key_event_t    last_q, last_d;
  logic          filt_en_q;

  key_event_t         ev_in;
  logic               empty_w, full_w;
  logic               repeat_hit, do_push, do_pop, lost;
  logic [ENTRY_W-1:0] rdata;

  assign ev_in   = make_event(extended, released, scancode);
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == FULL_CNT);

  // A held key re-sends its make code; drop it only if the last stored entry was the same make.
  assign repeat_hit = filt_en_q && last_valid_q && !released && !last_q.released &&
                      (last_q.extended == extended) && (last_q.scancode == scancode);

  assign do_pop  = rd && !empty_w;
  assign do_push = kb_interrupt && !repeat_hit && (!full_w || do_pop);
  assign lost    = kb_interrupt && !repeat_hit && full_w && !do_pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    last_valid_d = last_valid_q;
    last_d       = last_q;
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      last_valid_d = 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_d     = wr_ptr_q + AW'(1);
        last_valid_d = 1'b1;
        last_d       = ev_in;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - (AW+1)'(1);
      end
      if (lost) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      last_valid_q <= 1'b0;
      last_q       <= '0;
      filt_en_q    <= FILTER_DEFAULT;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      last_valid_q <= last_valid_d;
      last_q       <= last_d;
      if (cfg_we) begin
        filt_en_q <= filter_en;
      end
    end
  end

  ps2_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (do_push && !clear),
    .waddr_i (wr_ptr_q),
    .wdata_i (ev_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign dout     = empty_w ? '0 : rdata;
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed self-checking bench for ps2_key_fifo (DEPTH=8, filter enabled at reset).
module tb_ps2_key_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kb_interrupt = 1'b0;
  logic [7:0] scancode = 8'h00;
  logic       released = 1'b0;
  logic       extended = 1'b0;
  logic       rd = 1'b0;
  logic       clear = 1'b0;
  logic       filter_en = 1'b0;
  logic       cfg_we = 1'b0;
  logic [9:0] dout;
  logic       empty, full, overflow;
  logic [3:0] count;

  int n_checks = 0;
  int n_errors = 0;

  ps2_key_fifo #(.DEPTH(8), .FILTER_DEFAULT(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .kb_interrupt (kb_interrupt),
    .scancode     (scancode),
    .released     (released),
    .extended     (extended),
    .rd           (rd),
    .clear        (clear),
    .filter_en    (filter_en),
    .cfg_we       (cfg_we),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle with the given inputs; outputs are stable 1 time unit after the edge.
  task automatic cyc(input logic kb, input logic [7:0] code, input logic rel,
                     input logic ext, input logic rdv, input logic clr);
    kb_interrupt = kb; scancode = code; released = rel; extended = ext;
    rd = rdv; clear = clr;
    @(posedge clk);
    #1;
    kb_interrupt = 1'b0; rd = 1'b0; clear = 1'b0; cfg_we = 1'b0;
    $display("txn kb=%0b code=%02h rel=%0b ext=%0b rd=%0b clr=%0b -> count=%0d dout=%03h ovf=%0b",
             kb, code, rel, ext, rdv, clr, count, dout, overflow);
  endtask

  logic [9:0] q[$];
  logic [9:0] exp_v;
  logic [7:0] c;
  logic       do_rd;

  initial begin
    // Reset state
    #2;
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0); chk("rst_dout", dout, 10'h000);
    @(posedge clk); #1; rst_n = 1'b1;

    // Basic push / FWFT / pop
    cyc(1, 8'h1C, 0, 0, 0, 0);
    chk("push_dout", dout, 10'h01C); chk("push_count", count, 1); chk("push_empty", empty, 0);
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("pop_empty", empty, 1); chk("pop_dout", dout, 10'h000);
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("rd_empty_count", count, 0); chk("rd_empty_empty", empty, 1);

    // Repeat filter: last-accepted is still the make 1C from before the pop
    cyc(1, 8'h1C, 0, 0, 0, 0);
    chk("filt_after_pop", count, 0);
    cyc(0, 8'h00, 0, 0, 0, 1);
    cyc(1, 8'h1C, 0, 0, 0, 0); cyc(1, 8'h1C, 0, 0, 0, 0); cyc(1, 8'h1C, 0, 0, 0, 0);
    chk("filt_repeat_count", count, 1);
    cyc(1, 8'h1C, 1, 0, 0, 0);
    cyc(1, 8'h1C, 0, 0, 0, 0);
    chk("filt_break_make_count", count, 3); chk("filt_head", dout, 10'h01C);
    chk("filt_no_ovf", overflow, 0);
    cyc(1, 8'h1C, 0, 1, 0, 0);
    chk("filt_ext_differs", count, 4);
    cyc(0, 8'h00, 0, 0, 0, 1);
    chk("clear_count", count, 0);

    // Clear has priority and discards the event of the same cycle
    cyc(1, 8'h2A, 0, 0, 0, 1);
    chk("clear_prio_count", count, 0);

    // Filter enable change: same-cycle push uses the old enable
    cyc(1, 8'h2A, 0, 0, 0, 0);
    filter_en = 1'b0; cfg_we = 1'b1;
    cyc(1, 8'h2A, 0, 0, 0, 0);
    chk("cfg_old_en", count, 1);
    cyc(1, 8'h2A, 0, 0, 0, 0);
    chk("cfg_new_en", count, 2);
    cyc(0, 8'h00, 0, 0, 0, 1);

    // Overflow with 9 pushes
    for (int i = 0; i < 9; i++) begin
      c = 8'h10 + 8'(i);
      cyc(1, c, 0, 0, 0, 0);
    end
    chk("ovf_full", full, 1); chk("ovf_flag", overflow, 1); chk("ovf_count", count, 8);
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("ovf_sticky", overflow, 1);
    for (int i = 1; i < 8; i++) begin
      exp_v = 10'h010 + 10'(i);
      chk("ovf_order", dout, exp_v);
      cyc(0, 8'h00, 0, 0, 1, 0);
    end
    chk("ovf_9th_absent", empty, 1);
    cyc(0, 8'h00, 0, 0, 0, 1);
    chk("clr_count", count, 0); chk("clr_ovf", overflow, 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      c = 8'h20 + 8'(i);
      cyc(1, c, 0, 0, 0, 0);
    end
    chk("fill_full", full, 1);
    cyc(1, 8'h75, 0, 1, 1, 0);
    chk("fullpp_count", count, 8); chk("fullpp_ovf", overflow, 0);
    for (int i = 1; i < 8; i++) begin
      exp_v = 10'h020 + 10'(i);
      chk("fullpp_order", dout, exp_v);
      cyc(0, 8'h00, 0, 0, 1, 0);
    end
    chk("fullpp_tail", dout, 10'h275);
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("fullpp_empty", empty, 1);

    // Push and pop together while empty: push only
    cyc(1, 8'h33, 0, 0, 1, 0);
    chk("emptypp_count", count, 1); chk("emptypp_dout", dout, 10'h033);
    cyc(0, 8'h00, 0, 0, 1, 0);

    // Pointer wrap with interleaved traffic
    for (int i = 0; i < 20; i++) begin
      do_rd = (i % 3 != 0) && (q.size() > 0);
      if (do_rd) chk("wrap_order", dout, q.pop_front());
      c = 8'h40 + 8'(i);
      q.push_back({2'b00, c});
      cyc(1, c, 0, 0, do_rd, 0);
    end
    chk("wrap_count", count, 32'(q.size()));
    while (q.size() > 0) begin
      chk("wrap_drain", dout, q.pop_front());
      cyc(0, 8'h00, 0, 0, 1, 0);
    end
    chk("wrap_empty", empty, 1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) begin
      c = 8'h60 + 8'(i);
      cyc(1, c, 0, 0, 0, 0);
    end
    chk("pre_rst_count", count, 5);
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0); chk("arst_empty", empty, 1); chk("arst_dout", dout, 10'h000);
    @(posedge clk); #1; rst_n = 1'b1;
    cyc(1, 8'h1C, 0, 0, 0, 0); cyc(1, 8'h1C, 0, 0, 0, 0);
    chk("rst_filter_default", count, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
